// File: rtl/gpio_pkg.sv
// Shared constants and byte-lane helpers for the gpio peripheral.
// Contents:
//   WIDTH, SYNC_STG   port width and input synchroniser depth
//   OFS_*             register base offsets within the 16-byte window
//   IE_BIT            interrupt-enable bit position in CTRL
//   get_byte          extracts one byte lane from a 32-bit word
//   lane_mask         32-bit mask covering one byte lane
package gpio_pkg;

  localparam int WIDTH    = 32;
  localparam int SYNC_STG = 2;

  localparam logic [3:0] OFS_OUT  = 4'h0;
  localparam logic [3:0] OFS_CTRL = 4'h4;
  localparam logic [3:0] OFS_IN   = 4'h8;
  localparam logic [3:0] OFS_ISR  = 4'hC;

  localparam int IE_BIT = 0;

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] lane);
    logic [31:0] m;
    case (lane)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FF00;
      2'd2:    m = 32'h00FF_0000;
      2'd3:    m = 32'hFF00_0000;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Input synchroniser for the GPIO input port plus a one-cycle history flop.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   inp        raw input port, asynchronous to clk
//   sync       synchronised input (last synchroniser stage)
//   chg        bits of sync that differ from their previous-cycle value
module gpio_in_sync
  import gpio_pkg::*;
#(
  parameter int STAGES = SYNC_STG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] chg
);

  logic [WIDTH-1:0] stg [STAGES];
  logic [WIDTH-1:0] prev;

  // Synchroniser chain followed by the previous-value flop used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= {WIDTH{1'b0}};
      end
      prev <= {WIDTH{1'b0}};
    end else begin
      stg[0] <= inp;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
      prev <= stg[STAGES-1];
    end
  end

  assign sync = stg[STAGES-1];
  assign chg  = sync ^ prev;

endmodule

// File: rtl/gpio.sv
// 32-bit GPIO peripheral on an 8-bit byte-addressed bus.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   cs, rd, wr        chip select and one-cycle read/write strobes
//   addr              byte address; [3:2] register, [1:0] byte lane, [31:4] must be 0
//   data_i / data_o   write data / registered read data (held until the next read)
//   ready             one-cycle pulse after every qualified access
//   out               GPIO output port, driven straight from the OUT register
//   inp               GPIO input port, asynchronous to clk
//   interrupt         level interrupt: IE & |ISR, registered
module gpio
  import gpio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [7:0]       data_i,
  output logic [7:0]       data_o,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] inp,
  output logic             interrupt
);

  logic [WIDTH-1:0] out_reg;
  logic             ie;
  logic [WIDTH-1:0] isr;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] chg;

  logic             mapped;
  logic [3:0]       reg_ofs;
  logic [1:0]       lane;
  logic             acc;
  logic             do_wr;
  logic             do_rd;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [7:0]       rd_byte;

  gpio_in_sync #(.STAGES(SYNC_STG)) u_in_sync (
    .clk  (clk),
    .rst  (rst),
    .inp  (inp),
    .sync (sync),
    .chg  (chg)
  );

  assign mapped  = (addr[31:4] == 28'd0);
  assign reg_ofs = {addr[3:2], 2'b00};
  assign lane    = addr[1:0];
  assign acc     = cs & (rd | wr);
  // A write strobe takes priority; rd is ignored when wr is also high
  assign do_wr   = cs & wr & mapped;
  assign do_rd   = cs & rd & ~wr;
  assign wmask   = lane_mask(lane);
  assign wdata   = {4{data_i}};

  // Read mux: selected byte of the addressed register, zero when unmapped
  always_comb begin
    rd_byte = 8'h00;
    if (mapped) begin
      case (reg_ofs)
        OFS_OUT:  rd_byte = get_byte(out_reg, lane);
        OFS_CTRL: rd_byte = (lane == 2'd0) ? {7'b000_0000, ie} : 8'h00;
        OFS_IN:   rd_byte = get_byte(sync, lane);
        OFS_ISR:  rd_byte = get_byte(isr, lane);
        default:  rd_byte = 8'h00;
      endcase
    end else begin
      rd_byte = 8'h00;
    end
  end

  // Write-one-to-clear mask for the ISR byte lane being written
  always_comb begin
    w1c = {WIDTH{1'b0}};
    if (do_wr && (reg_ofs == OFS_ISR)) begin
      w1c = wdata & wmask;
    end else begin
      w1c = {WIDTH{1'b0}};
    end
  end

  // Register file, read data, access handshake and interrupt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg   <= {WIDTH{1'b0}};
      ie        <= 1'b0;
      isr       <= {WIDTH{1'b0}};
      data_o    <= 8'h00;
      ready     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (do_wr && (reg_ofs == OFS_OUT)) begin
        out_reg <= (out_reg & ~wmask) | (wdata & wmask);
      end
      if (do_wr && (reg_ofs == OFS_CTRL) && (lane == 2'd0)) begin
        ie <= data_i[IE_BIT];
      end
      // New changes are OR-ed in after the clear, so a same-cycle set wins
      isr <= (isr & ~w1c) | chg;
      if (do_rd) begin
        data_o <= rd_byte;
      end
      ready     <= acc;
      interrupt <= ie & (|isr);
    end
  end

  assign out = out_reg;

endmodule

// File: tb/tb_gpio.sv
module tb_gpio;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        ready;
  logic [31:0] out;
  logic [31:0] inp;
  logic        interrupt;

  int total;
  int bad;

  logic       r_rdy;
  logic [7:0] r_dat;

  gpio dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .ready     (ready),
    .out       (out),
    .inp       (inp),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one bus cycle at a falling edge; returns ready/data_o sampled one cycle later.
  task automatic access(input logic c, input logic r, input logic w,
                        input logic [31:0] a, input logic [7:0] d,
                        output logic rdy, output logic [7:0] dout);
    @(negedge clk);
    cs = c; rd = r; wr = w; addr = a; data_i = d;
    @(negedge clk);
    rdy  = ready;
    dout = data_o;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; data_i = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; data_i = 8'h00;
    inp = 32'hxxxx_xxxx;
    idle(3);
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=00000000", out); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    inp = 32'h0;
    idle(1);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_input_read;
    inp = 32'hF0F0_F0F0;
    idle(3);
    access(1'b1, 1'b1, 1'b0, 32'h8, 8'h00, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b1) begin bad++; $display("FAIL in_ready got=%b exp=1", r_rdy); end
    total++; if (r_dat !== 8'hF0) begin bad++; $display("FAIL in_byte0 got=%h exp=F0", r_dat); end
    idle(1);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ready_width got=%b exp=0", ready); end
    access(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'h00) begin bad++; $display("FAIL out_read got=%h exp=00", r_dat); end
    access(1'b1, 1'b1, 1'b0, 32'h4, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'h00) begin bad++; $display("FAIL ctrl_read got=%h exp=00", r_dat); end
  endtask

  task automatic test_cs_and_isr;
    access(1'b0, 1'b1, 1'b0, 32'h8, 8'h00, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b0) begin bad++; $display("FAIL nocs_ready got=%b exp=0", r_rdy); end
    total++; if (r_dat !== 8'h00) begin bad++; $display("FAIL nocs_data got=%h exp=00", r_dat); end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, 1'b0, 32'hC + i, 8'h00, r_rdy, r_dat);
      total++; if (r_dat !== 8'hF0) begin bad++; $display("FAIL isr_lane%0d got=%h exp=F0", i, r_dat); end
    end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_ie0 got=%b exp=0", interrupt); end
  endtask

  task automatic test_change_and_nocs_write;
    inp = 32'h0F0F_0F0F;
    idle(3);
    access(1'b1, 1'b1, 1'b0, 32'h8, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'h0F) begin bad++; $display("FAIL in_0f got=%h exp=0F", r_dat); end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, 1'b0, 32'hC + i, 8'h00, r_rdy, r_dat);
      total++; if (r_dat !== 8'hFF) begin bad++; $display("FAIL isr_ff_lane%0d got=%h exp=FF", i, r_dat); end
    end
    access(1'b0, 1'b0, 1'b1, 32'h4, 8'h01, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b0) begin bad++; $display("FAIL nocs_wr_ready got=%b exp=0", r_rdy); end
    idle(2);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL nocs_wr_irq got=%b exp=0", interrupt); end
  endtask

  task automatic test_interrupt;
    access(1'b1, 1'b0, 1'b1, 32'h4, 8'h01, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b1) begin bad++; $display("FAIL ie_wr_ready got=%b exp=1", r_rdy); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_latency got=%b exp=0", interrupt); end
    idle(1);
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", interrupt); end
    access(1'b1, 1'b1, 1'b0, 32'h4, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'h01) begin bad++; $display("FAIL ctrl_ie_read got=%h exp=01", r_dat); end
    inp = 32'hFFFF_FFFF;
    idle(3);
    access(1'b1, 1'b1, 1'b0, 32'h8, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'hFF) begin bad++; $display("FAIL in_ff got=%h exp=FF", r_dat); end
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b0, 1'b1, 32'hC + i, 8'hFF, r_rdy, r_dat);
    end
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_partial_clear got=%b exp=1", interrupt); end
    access(1'b1, 1'b0, 1'b1, 32'hF, 8'hFF, r_rdy, r_dat);
    idle(2);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", interrupt); end
    access(1'b1, 1'b1, 1'b0, 32'hD, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'h00) begin bad++; $display("FAIL isr_after_clear got=%h exp=00", r_dat); end
  endtask

  task automatic test_out_and_unmapped;
    access(1'b1, 1'b0, 1'b1, 32'h2, 8'hA5, r_rdy, r_dat);
    total++; if (out !== 32'h00A5_0000) begin bad++; $display("FAIL out_byte2 got=%h exp=00A50000", out); end
    access(1'b1, 1'b1, 1'b0, 32'h10, 8'h00, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b1) begin bad++; $display("FAIL unmapped_ready got=%b exp=1", r_rdy); end
    total++; if (r_dat !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%h exp=00", r_dat); end
    access(1'b1, 1'b0, 1'b1, 32'h12, 8'h77, r_rdy, r_dat);
    total++; if (out !== 32'h00A5_0000) begin bad++; $display("FAIL unmapped_write got=%h exp=00A50000", out); end
    access(1'b1, 1'b1, 1'b0, 32'h2, 8'h00, r_rdy, r_dat);
    total++; if (r_dat !== 8'hA5) begin bad++; $display("FAIL out_readback got=%h exp=A5", r_dat); end
    access(1'b1, 1'b1, 1'b1, 32'h1, 8'h3C, r_rdy, r_dat);
    total++; if (r_rdy !== 1'b1) begin bad++; $display("FAIL rdwr_ready got=%b exp=1", r_rdy); end
    total++; if (r_dat !== 8'hA5) begin bad++; $display("FAIL rdwr_data_o got=%h exp=A5", r_dat); end
    total++; if (out !== 32'h00A5_3C00) begin bad++; $display("FAIL rdwr_out got=%h exp=00A53C00", out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_input_read;
    test_cs_and_isr;
    test_change_and_nocs_write;
    test_interrupt;
    test_out_and_unmapped;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
